// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM; optional watchdog under `ARB_TIMEOUT_EN.
// Latency: grant 1 cycle after valid, ready 1 cycle after ram_ready, back in IDLE 1 cycle later (4 cycles min).
// Backpressure: requesters hold valid until their ready pulse; the RAM stalls a grant by holding ram_ready low.
module ram_arbiter #(
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    input  logic [3:0]            m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [31:0]           m0_write_data,
    output logic [31:0]           m0_read_data,
    output logic                  m0_ready,
    input  logic                  m1_valid,
    input  logic [3:0]            m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [31:0]           m1_write_data,
    output logic [31:0]           m1_read_data,
    output logic                  m1_ready,
    output logic                  ram_cs,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,
    input  logic                  ram_ready
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                  timeout_error
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] m0_read_data_q, m0_read_data_d;
    logic [31:0] m1_read_data_q, m1_read_data_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic        access_end;
    logic        timed_out;
    logic [31:0] rdata_sel;

`ifdef ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_error_q, timeout_error_d;

    // A real ram_ready arriving in the last watchdog cycle wins over the timeout.
    assign timed_out = (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) && !ram_ready;
`else
    assign timed_out = 1'b0;
`endif

    assign access_end = ram_ready || timed_out;
    assign rdata_sel  = timed_out ? 32'hdeadbeef : ram_read_data;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        m0_read_data_d = m0_read_data_q;
        m1_read_data_d = m1_read_data_q;
        m0_ready_d     = 1'b0;
        m1_ready_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        wdog_d          = wdog_q;
        timeout_error_d = timeout_error_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                wdog_d = '0;
`endif
                if (m0_valid && m1_valid) begin
                    state_d = last_grant_q ? GRANT0 : GRANT1;
                end else if (m0_valid) begin
                    state_d = GRANT0;
                end else if (m1_valid) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (access_end) begin
                    m0_read_data_d = rdata_sel;
                    m0_ready_d     = 1'b1;
                    last_grant_d   = 1'b0;
                    state_d        = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                wdog_d = wdog_q + WDOG_W'(1);
                if (timed_out) begin
                    timeout_error_d = 1'b1;
                end
`endif
            end
            GRANT1: begin
                if (access_end) begin
                    m1_read_data_d = rdata_sel;
                    m1_ready_d     = 1'b1;
                    last_grant_d   = 1'b1;
                    state_d        = DONE;
                end
`ifdef ARB_TIMEOUT_EN
                wdog_d = wdog_q + WDOG_W'(1);
                if (timed_out) begin
                    timeout_error_d = 1'b1;
                end
`endif
            end
            // DONE lets the finished requester drop valid before arbitration resumes.
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b1;
            m0_read_data_q <= '0;
            m1_read_data_q <= '0;
            m0_ready_q     <= 1'b0;
            m1_ready_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            m0_read_data_q <= m0_read_data_d;
            m1_read_data_q <= m1_read_data_d;
            m0_ready_q     <= m0_ready_d;
            m1_ready_q     <= m1_ready_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q          <= '0;
            timeout_error_q <= 1'b0;
        end else begin
            wdog_q          <= wdog_d;
            timeout_error_q <= timeout_error_d;
        end
    end

    assign timeout_error = timeout_error_q;
`endif

    // RAM-side mux defaults to requester 0 whenever requester 1 is not granted.
    assign ram_cs         = (state_q == GRANT0) || (state_q == GRANT1);
    assign ram_we         = (state_q == GRANT1) ? m1_we         : m0_we;
    assign ram_address    = (state_q == GRANT1) ? m1_address    : m0_address;
    assign ram_write_data = (state_q == GRANT1) ? m1_write_data : m0_write_data;

    assign m0_read_data = m0_read_data_q;
    assign m1_read_data = m1_read_data_q;
    assign m0_ready     = m0_ready_q;
    assign m1_ready     = m1_ready_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter; watchdog scenario included when ARB_TIMEOUT_EN is defined.
module tb_ram_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_valid, m1_valid;
    logic [3:0]    m0_we, m1_we;
    logic [AW-1:0] m0_address, m1_address;
    logic [31:0]   m0_write_data, m1_write_data;
    logic [31:0]   m0_read_data, m1_read_data;
    logic          m0_ready, m1_ready;
    logic          ram_cs;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_write_data;
    logic [31:0]   ram_read_data;
    logic          ram_ready;
    logic          ram_en;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_error;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0_valid       (m0_valid),
        .m0_we          (m0_we),
        .m0_address     (m0_address),
        .m0_write_data  (m0_write_data),
        .m0_read_data   (m0_read_data),
        .m0_ready       (m0_ready),
        .m1_valid       (m1_valid),
        .m1_we          (m1_we),
        .m1_address     (m1_address),
        .m1_write_data  (m1_write_data),
        .m1_read_data   (m1_read_data),
        .m1_ready       (m1_ready),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data),
        .ram_ready      (ram_ready)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_error  (timeout_error)
`endif
    );

    // RAM model: acknowledges one cycle after select when enabled.
    always @(posedge clk) begin
        if (rst) ram_ready <= 1'b0;
        else     ram_ready <= ram_en && ram_cs && !ram_ready;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got_q[$];
        int ovl;
        int cs_done;
        logic p0, p1;

        rst = 1'b1; ram_en = 1'b0; ram_read_data = 32'h0;
        m0_valid = 1'b0; m0_we = 4'h0; m0_address = '0; m0_write_data = '0;
        m1_valid = 1'b0; m1_we = 4'h0; m1_address = '0; m1_write_data = '0;
        tick(); tick();
        check_eq("rst_cs", ram_cs, 1'b0);
        check_eq("rst_m0_ready", m0_ready, 1'b0);
        check_eq("rst_m1_ready", m1_ready, 1'b0);
        check_eq("rst_m0_rdata", m0_read_data, 32'h0);
        check_eq("rst_m1_rdata", m1_read_data, 32'h0);
`ifdef ARB_TIMEOUT_EN
        check_eq("rst_timeout", timeout_error, 1'b0);
`endif
        rst = 1'b0;
        tick();

        // Single read by m0: cs in cycle 1, ram_ready cycle 2, ready cycle 3.
        ram_en = 1'b1; ram_read_data = 32'h12345678;
        m0_valid = 1'b1; m0_we = 4'h0; m0_address = 12'h010;
        tick();
        check_eq("rd_c1_cs", ram_cs, 1'b1);
        check_eq("rd_c1_addr", ram_address, 12'h010);
        check_eq("rd_c1_we", ram_we, 4'h0);
        tick();
        check_eq("rd_c2_m0_ready", m0_ready, 1'b0);
        tick();
        check_eq("rd_c3_m0_ready", m0_ready, 1'b1);
        check_eq("rd_c3_rdata", m0_read_data, 32'h12345678);
        check_eq("rd_c3_m1_ready", m1_ready, 1'b0);
        check_eq("rd_c3_cs", ram_cs, 1'b0);
        m0_valid = 1'b0;
        tick();
        check_eq("rd_c4_m0_ready", m0_ready, 1'b0);
        check_eq("rd_c4_cs", ram_cs, 1'b0);

        // Write passthrough from m1.
        ram_read_data = 32'h0;
        m1_valid = 1'b1; m1_we = 4'b0011; m1_address = 12'h7ff; m1_write_data = 32'ha5a5a5a5;
        tick();
        check_eq("wr_cs", ram_cs, 1'b1);
        check_eq("wr_we", ram_we, 4'b0011);
        check_eq("wr_addr", ram_address, 12'h7ff);
        check_eq("wr_data", ram_write_data, 32'ha5a5a5a5);
        tick(); tick();
        check_eq("wr_m1_ready", m1_ready, 1'b1);
        check_eq("wr_m0_ready", m0_ready, 1'b0);
        m1_valid = 1'b0;
        tick();
        check_eq("wr_m1_ready_drop", m1_ready, 1'b0);

        // Contention from reset release: 0,1,0,1.
        rst = 1'b1;
        m0_valid = 1'b1; m0_we = 4'h0; m0_address = 12'h100;
        m1_valid = 1'b1; m1_we = 4'h0; m1_address = 12'h200;
        ram_read_data = 32'h0badf00d;
        tick();
        rst = 1'b0;
        ovl = 0; cs_done = 0; p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
            tick();
            if ((m0_ready && p0) || (m1_ready && p1)) ovl++;
            if ((m0_ready || m1_ready) && ram_cs) cs_done++;
            if (m0_ready) got_q.push_back(0);
            if (m1_ready) got_q.push_back(1);
            p0 = m0_ready; p1 = m1_ready;
        end
        check_eq("cont_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size(); i++)
            check_eq($sformatf("cont_order%0d", i), got_q[i], i % 2);
        check_eq("cont_ready_width", ovl, 0);
        check_eq("cont_cs_in_done", cs_done, 0);
        check_eq("cont_m1_rdata", m1_read_data, 32'h0badf00d);
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick();

        // Reset while m1 is granted and the RAM never answers.
        ram_en = 1'b0;
        m1_valid = 1'b1;
        tick();
        check_eq("rstacc_cs_grant", ram_cs, 1'b1);
        check_eq("rstacc_addr", ram_address, 12'h200);
        tick(); tick();
        rst = 1'b1;
        tick();
        check_eq("rstacc_cs_after", ram_cs, 1'b0);
        check_eq("rstacc_m1_ready", m1_ready, 1'b0);
        rst = 1'b0;
        ram_en = 1'b1;
        m0_valid = 1'b1;
        tick();
        check_eq("rstacc_tie_cs", ram_cs, 1'b1);
        check_eq("rstacc_tie_addr", ram_address, 12'h100);
        tick();
        check_eq("rstacc_no_m1_ready", m1_ready, 1'b0);
        tick();
        check_eq("rstacc_m0_ready", m0_ready, 1'b1);
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick(); tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog: RAM silent, ready after 16 grant cycles with the poison word.
        ram_en = 1'b0;
        m0_valid = 1'b1; m0_address = 12'h020;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq($sformatf("wd_grant%0d_m0_ready", i), m0_ready, 1'b0);
        end
        check_eq("wd_cs_last", ram_cs, 1'b1);
        tick();
        check_eq("wd_m0_ready", m0_ready, 1'b1);
        check_eq("wd_rdata", m0_read_data, 32'hdeadbeef);
        check_eq("wd_error", timeout_error, 1'b1);
        m0_valid = 1'b0;
        tick(); tick(); tick();
        check_eq("wd_error_sticky", timeout_error, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("wd_error_clear", timeout_error, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter that shares the single-port FPGA RAM between the CPU memory bus (requester 0) and an auxiliary bus master such as a DMA or UART block (requester 1). It sits between the top-level CPU memory decode and the RAM instance and sequences each access through a grant/complete/release FSM. It returns registered read data and a one-cycle ready pulse to the winning requester. An optional watchdog terminates accesses that the RAM never acknowledges.

## Interface
- ADDR_WIDTH, 12: word address width of the RAM port.
- TIMEOUT_CYCLES, 16: watchdog limit in cycles, counted from slave select. Used only with the watchdog feature.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- m0_valid / m1_valid  in  1  access request. Held high until the requester sees its ready.
- m0_we / m1_we  in  4  byte write strobes. 4'h0 means a read.
- m0_address / m1_address  in  ADDR_WIDTH  word address.
- m0_write_data / m1_write_data  in  32  write data.
- m0_read_data / m1_read_data  out  32  registered read data. Valid when the matching ready is high.
- m0_ready / m1_ready  out  1  one-cycle completion pulse.
- ram_cs  out  1  RAM select.
- ram_we  out  4  strobes from the granted requester.
- ram_address  out  ADDR_WIDTH  address from the granted requester.
- ram_write_data  out  32  write data from the granted requester.
- ram_read_data  in  32  RAM read data.
- ram_ready  in  1  RAM completion.
- timeout_error  out  1  sticky watchdog flag. Exists only with ARB_TIMEOUT_EN.

## Operation
- FSM states: IDLE, GRANT0, GRANT1, DONE.
- **IDLE:**
  - Exactly one valid → GRANT of that requester.
  - Both valid → grant the requester not served last. last_grant resets to 1, so requester 0 wins the first tie.
  - Neither valid → stay in IDLE.
- **GRANTx:**
  - ram_cs = 1. ram_we, ram_address and ram_write_data are muxed combinationally from requester x.
  - Stay in GRANTx until ram_ready = 1.
  - On ram_ready: register ram_read_data into mx_read_data, set mx_ready = 1 for the next cycle, update last_grant = x, go to DONE.
- **DONE:**
  - One cycle. mx_ready = 1, ram_cs = 0.
  - This cycle absorbs the requester dropping valid, so a completed request is never re-granted.
  - Next state is IDLE unconditionally.
- A requester that is not granted keeps ready = 0 and its read_data unchanged.
- ram_we, ram_address and ram_write_data are don't-care when ram_cs = 0 and are driven from requester 0 in that case.
- Valid being withdrawn during GRANTx is a protocol violation. The access still completes and ready is still pulsed.

## Timing
- All outputs reset to 0: ready, read_data, ram_cs, timeout_error.
- Reset state: FSM = IDLE, last_grant = 1, watchdog = 0.
- Reset mid-access: ram_cs is low from the first cycle after the reset edge. No ready is issued for the aborted access.
- Minimum latency with the RAM's one-cycle ready:
  - Valid sampled in IDLE at cycle 0.
  - ram_cs high in cycle 1.
  - ram_ready in cycle 2.
  - mx_ready in cycle 3.
  - Back in IDLE in cycle 4.
- Back-to-back throughput: one access per 4 cycles.
- Both valid continuously: grants alternate strictly, 0, 1, 0, 1, …
- ram_ready is ignored outside the GRANT states.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - A watchdog counter clears on GRANT entry and increments each GRANT cycle.
  - If the counter reaches TIMEOUT_CYCLES without ram_ready, the arbiter completes the access as if acknowledged, with read_data = 32'hdeadbeef.
  - It then sets timeout_error (sticky, cleared only by rst) and goes to DONE.
- **ARB_TIMEOUT_EN not defined:**
  - No counter and no timeout_error port.
  - A GRANT state waits indefinitely for ram_ready.

## Test plan
- **Single read:** m0 reads address 0x010; the RAM model returns 0x12345678 one cycle after cs → m0_ready pulses exactly once in cycle 3 with m0_read_data = 0x12345678, and m1_ready stays 0.
- **Write passthrough:** m1 writes 0xa5a5a5a5 with we 4'b0011 to 0x7ff → during m1's grant, ram_we = 4'b0011, ram_address = 0x7ff and ram_write_data = 0xa5a5a5a5; m1_ready pulses once.
- **Contention after reset:** both valid from reset release for 4 accesses → grant order is 0, 1, 0, 1; each ready is one cycle wide; ram_cs is never high in DONE.
- **Reset during an access:** assert rst while in GRANT1 with ram_ready held low → ram_cs is 0 the next cycle, no m1_ready pulse, and a later tie is granted to requester 0.
- **Watchdog (ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16):** the RAM never sends ready → m0_ready pulses after 16 GRANT cycles with read_data 0xdeadbeef, and timeout_error = 1 and stays 1 until rst.
